// File: rtl/tea_enc_if.sv
`default_nettype none
// ============================================================================
// Module      : tea_enc_if
// Description : Request/result bundle between a TEA encryptor and its user.
// Revision    : 1.0 - initial release
// ============================================================================
interface tea_enc_if;
    logic         ena;
    logic         start;
    logic [63:0]  data;
    logic [127:0] key;
    logic         busy;
    logic         rdy;
    logic [63:0]  result;

    modport master (
        output ena, start, data, key,
        input  busy, rdy, result
    );

    modport slave (
        input  ena, start, data, key,
        output busy, rdy, result
    );
endinterface
`default_nettype wire

// File: rtl/tea_enc.sv
`default_nettype none
// ============================================================================
// Module      : tea_enc
// Description : Iterative TEA block encryptor, one round per enabled cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tea_enc #(
    parameter logic [31:0] DELTA  = 32'h9E3779B9,
    parameter int unsigned ROUNDS = 32
) (
    input  wire logic  clk,
    input  wire logic  rst,
    tea_enc_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ENC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [5:0] c_LAST_ROUND = 6'(ROUNDS);

    state_t      r_state;
    state_t      w_state_nx;
    logic [31:0] r_v0, r_v1, r_sum;
    logic [31:0] r_k0, r_k1, r_k2, r_k3;
    logic [5:0]  r_cnt;

    logic [31:0] w_sum_nx;
    logic [31:0] w_v0_nx;
    logic [31:0] w_v1_nx;
    logic [5:0]  w_cnt_nx;

    // v1 update depends on the freshly computed v0 of the same round
    assign w_sum_nx = r_sum + DELTA;
    assign w_v0_nx  = r_v0 + (((r_v1 << 4) + r_k0) ^ (r_v1 + w_sum_nx) ^ ((r_v1 >> 5) + r_k1));
    assign w_v1_nx  = r_v1 + (((w_v0_nx << 4) + r_k2) ^ (w_v0_nx + w_sum_nx) ^ ((w_v0_nx >> 5) + r_k3));
    assign w_cnt_nx = r_cnt + 6'd1;

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_nx = S_ENC;
            S_ENC:   if (w_cnt_nx == c_LAST_ROUND) w_state_nx = S_DONE;
            S_DONE:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else if (bus.ena) begin
            r_state <= w_state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v0  <= 32'h0;
            r_v1  <= 32'h0;
            r_sum <= 32'h0;
            r_cnt <= 6'd0;
            r_k0  <= 32'h0;
            r_k1  <= 32'h0;
            r_k2  <= 32'h0;
            r_k3  <= 32'h0;
        end else if (bus.ena) begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_v0  <= bus.data[63:32];
                        r_v1  <= bus.data[31:0];
                        r_k0  <= bus.key[127:96];
                        r_k1  <= bus.key[95:64];
                        r_k2  <= bus.key[63:32];
                        r_k3  <= bus.key[31:0];
                        r_sum <= 32'h0;
                        r_cnt <= 6'd0;
                    end
                end
                S_ENC: begin
                    r_v0  <= w_v0_nx;
                    r_v1  <= w_v1_nx;
                    r_sum <= w_sum_nx;
                    r_cnt <= w_cnt_nx;
                end
                default: ;
            endcase
        end
    end

    // Result stays on the v0/v1 registers so it holds through IDLE
    assign bus.busy   = (r_state != S_IDLE);
    assign bus.rdy    = (r_state == S_DONE);
    assign bus.result = {r_v0, r_v1};

endmodule
`default_nettype wire

// File: tb/tb_tea_enc.sv
`default_nettype none
// ============================================================================
// Module      : tb_tea_enc
// Description : Scoreboard bench for tea_enc against a software TEA model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tea_enc;

    localparam logic [31:0] c_DELTA  = 32'h9E3779B9;
    localparam int          c_ROUNDS = 32;

    logic clk;
    logic rst;
    tea_enc_if tif();

    tea_enc #(.DELTA(c_DELTA), .ROUNDS(c_ROUNDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (tif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0]  d;
        logic [127:0] k;
        logic [63:0]  exp;
    } item_t;

    item_t sb[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    n_pops   = 0;
    int    ref_cnt  = 0;
    bit    mon_en   = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    endtask

    function automatic logic [63:0] tea_model(input logic [63:0] d, input logic [127:0] k);
        logic [31:0] v0, v1, s;
        v0 = d[63:32]; v1 = d[31:0]; s = 32'h0;
        for (int i = 0; i < c_ROUNDS; i++) begin
            s  = s + c_DELTA;
            v0 = v0 + (((v1 << 4) + k[127:96]) ^ (v1 + s) ^ ((v1 >> 5) + k[95:64]));
            v1 = v1 + (((v0 << 4) + k[63:32]) ^ (v0 + s) ^ ((v0 >> 5) + k[31:0]));
        end
        return {v0, v1};
    endfunction

    function automatic logic [63:0] tea_dec(input logic [63:0] c, input logic [127:0] k);
        logic [31:0] v0, v1, s;
        v0 = c[63:32]; v1 = c[31:0]; s = 32'hC6EF3720;
        for (int i = 0; i < c_ROUNDS; i++) begin
            v1 = v1 - (((v0 << 4) + k[63:32]) ^ (v0 + s) ^ ((v0 >> 5) + k[31:0]));
            v0 = v0 - (((v1 << 4) + k[127:96]) ^ (v1 + s) ^ ((v1 >> 5) + k[95:64]));
            s  = s - c_DELTA;
        end
        return {v0, v1};
    endfunction

    // Reference timing: 0 idle, 1..ROUNDS encrypting, ROUNDS+1 done
    always @(posedge clk) begin
        if (rst) begin
            if (sb.size() > 0) sb.delete();
            ref_cnt <= 0;
        end else if (tif.ena) begin
            if (ref_cnt == 0) begin
                if (tif.start) begin
                    sb.push_back('{d: tif.data, k: tif.key, exp: tea_model(tif.data, tif.key)});
                    ref_cnt <= 1;
                end
            end else if (ref_cnt == c_ROUNDS + 1) begin
                ref_cnt <= 0;
            end else begin
                ref_cnt <= ref_cnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            check_eq("busy", 64'(tif.busy), 64'(ref_cnt != 0));
            check_eq("rdy", 64'(tif.rdy), 64'(ref_cnt == c_ROUNDS + 1));
            if (tif.rdy && tif.ena) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_rdy", 64'(1), 64'(0));
                end else begin
                    item_t it;
                    it = sb.pop_front();
                    n_pops++;
                    check_eq("result", tif.result, it.exp);
                    check_eq("roundtrip", tea_dec(tif.result, it.k), it.d);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [63:0] d, input logic [127:0] k, input int ena_pct);
        tif.ena = 1'b1; tif.data = d; tif.key = k; tif.start = 1'b1;
        tick();
        tif.start = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tif.data = {$urandom, $urandom};
            tif.key  = {$urandom, $urandom, $urandom, $urandom};
            tif.ena  = ($urandom_range(99) < ena_pct);
            tick();
            if (!tif.busy) break;
        end
        tif.ena = 1'b1;
        check_eq("op_complete", 64'(tif.busy), 64'(0));
    endtask

    initial begin
        int          bcnt, rcnt, n0;
        logic [63:0] zres;
        tif.ena = 1'b0; tif.start = 1'b0; tif.data = '0; tif.key = '0;
        rst = 1'b1;
        tick(); tick();
        @(negedge clk);
        check_eq("reset_busy", 64'(tif.busy), 64'(0));
        check_eq("reset_rdy", 64'(tif.rdy), 64'(0));
        check_eq("reset_result", tif.result, 64'h0);
        tick();
        rst = 1'b0; tif.ena = 1'b1;
        mon_en = 1'b1;
        tick();

        // Zero vector with explicit latency and busy-length count
        tif.start = 1'b1;
        tick();
        tif.start = 1'b0;
        bcnt = 0; rcnt = 0; zres = '0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tif.rdy) begin rcnt++; zres = tif.result; end
            if (tif.busy) bcnt++;
            else break;
        end
        check_eq("zero_busy_cycles", 64'(bcnt), 64'(33));
        check_eq("zero_rdy_count", 64'(rcnt), 64'(1));
        check_eq("zero_result", zres, 64'h41EA3A0A94BAA940);
        check_eq("zero_hold_idle", tif.result, 64'h41EA3A0A94BAA940);
        tick();

        // DONE held by ena=0 keeps rdy asserted
        tif.data = {$urandom, $urandom}; tif.key = {$urandom, $urandom, $urandom, $urandom};
        tif.start = 1'b1;
        tick();
        tif.start = 1'b0;
        for (int i = 0; i < 100 && !tif.rdy; i++) tick();
        check_eq("done_reached", 64'(tif.rdy), 64'(1));
        tif.ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("rdy_held", 64'(tif.rdy), 64'(1));
        end
        tif.ena = 1'b1;
        tick();
        check_eq("done_exit", 64'(tif.busy), 64'(0));

        for (int n = 0; n < 1000; n++)
            run_op({$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, (n < 800) ? 100 : 70);

        for (int n = 0; n < 5; n++)
            run_op({$urandom, $urandom}, {"kluh", " si ", "ht  ", "ucky"}, 100);

        // Abort mid-operation
        n0 = n_pops;
        tif.data = {$urandom, $urandom}; tif.key = {$urandom, $urandom, $urandom, $urandom};
        tif.start = 1'b1;
        tick();
        tif.start = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("abort_busy", 64'(tif.busy), 64'(0));
        repeat (40) tick();
        check_eq("abort_no_rdy", 64'(n_pops - n0), 64'(0));
        run_op({$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 100);

        // start held: ops accepted at 0, 34 and 68 cycles in a 90-cycle window
        n0 = n_pops;
        tif.start = 1'b1;
        repeat (90) tick();
        tif.start = 1'b0;
        repeat (40) tick();
        check_eq("held_start_ops", 64'(n_pops - n0), 64'(3));
        check_eq("sb_drained", 64'(sb.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
